latch_write_arbiter: RTL

LATCH_WRITE_ARBITER -- requirements
Module: latch_write_arbiter

---
 rtl/latch_write_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/latch_write_arbiter.sv
// Arbitrates four requesters onto a bank of four level-sensitive latches using a SETUP/PULSE/HOLD write sequence.
// Define LATCH_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (lowest index wins).
module latch_write_arbiter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] wdata,
  input  logic [7:0]     waddr,
  output logic [3:0]     gnt,
  output logic [3:0]     done,
  output logic [W-1:0]   lat_d,
  output logic [3:0]     lat_e,
  output logic           busy
);

  localparam int NREQ = 4;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t         state, state_n;
  logic [3:0]     gnt_n, done_n, lat_e_n;
  logic [W-1:0]   lat_d_n;
  logic           busy_n;
  logic [1:0]     addr, addr_n;
  logic [1:0]     win;
`ifdef LATCH_ARB_RR_EN
  logic [1:0]     ptr, ptr_n;
`endif

  // Winner selection; only consumed in IDLE when some request is pending.
  always_comb begin
    win = '0;
`ifdef LATCH_ARB_RR_EN
    // Walk offsets from farthest to nearest so the entry right after ptr wins.
    for (int o = NREQ - 1; o >= 0; o--) begin
      if (req[ptr + 2'(o + 1)]) win = ptr + 2'(o + 1);
    end
`else
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) win = 2'(i);
    end
`endif
  end

  // lat_d only moves on entry to SETUP, so it is stable around every enable pulse.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    done_n  = '0;
    lat_e_n = '0;
    lat_d_n = lat_d;
    addr_n  = addr;
`ifdef LATCH_ARB_RR_EN
    ptr_n   = ptr;
`endif
    unique case (state)
      IDLE: begin
        if (req != '0) begin
          state_n = SETUP;
          gnt_n   = 4'b0001 << win;
          lat_d_n = wdata[int'(win) * W +: W];
          addr_n  = waddr[int'(win) * 2 +: 2];
`ifdef LATCH_ARB_RR_EN
          ptr_n   = win;
`endif
        end
      end
      SETUP: begin
        state_n = PULSE;
        lat_e_n = 4'b0001 << addr;
      end
      PULSE: begin
        state_n = HOLD;
        done_n  = gnt;
      end
      HOLD: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      lat_e <= '0;
      lat_d <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      done  <= done_n;
      lat_e <= lat_e_n;
      lat_d <= lat_d_n;
      busy  <= busy_n;
    end
  end

`ifdef LATCH_ARB_RR_EN
  // Pointer at 3 after reset makes requester 0 the first in line.
  always_ff @(posedge clk) begin
    if (!nrst) ptr <= 2'd3;
    else       ptr <= ptr_n;
  end
`endif

  // Captured target entry is pure data and needs no reset.
  always_ff @(posedge clk) begin
    addr <= addr_n;
  end

endmodule
